// File: rtl/periph_fifo_id_pkg.sv
// Shared defaults and helpers for the peripheral request FIFO.
// Build option: PERIPH_FIFO_ID_RESP_REG_EN registers the response path.
package periph_fifo_id_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ID_W_DEF   = 8;
  localparam int unsigned DEPTH_DEF  = 4;
  localparam int unsigned MAX_OT_DEF = 8;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/periph_fifo_id_mem.sv
// Request storage: DEPTH x DW array with wrap pointers, count and flush.
// Head entry is read combinationally; storage resets to zero.
module periph_fifo_id_mem
  import periph_fifo_id_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned CW   = cnt_width(DEPTH),
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/periph_fifo_id_ot.sv
// Peripheral request buffer with outstanding-transaction limiter.
// Build option: PERIPH_FIFO_ID_RESP_REG_EN registers the response path.
module periph_fifo_id_ot
  import periph_fifo_id_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = ADDR_W_DEF,
  parameter int unsigned DATA_WIDTH      = DATA_W_DEF,
  parameter int unsigned ID_WIDTH        = ID_W_DEF,
  parameter int unsigned BYTE_ENABLE_BIT = DATA_WIDTH / 8,
  parameter int unsigned DEPTH           = DEPTH_DEF,
  parameter int unsigned MAX_OUTSTANDING = MAX_OT_DEF,
  localparam int unsigned IW = cnt_width(MAX_OUTSTANDING)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       data_req_i,
  input  logic [ADDR_WIDTH-1:0]      data_add_i,
  input  logic                       data_we_n_i,
  input  logic [DATA_WIDTH-1:0]      data_wdata_i,
  input  logic [BYTE_ENABLE_BIT-1:0] data_be_i,
  input  logic [ID_WIDTH-1:0]        data_id_i,
  output logic                       data_gnt_o,
  output logic                       data_req_o,
  output logic [ADDR_WIDTH-1:0]      data_add_o,
  output logic                       data_we_n_o,
  output logic [DATA_WIDTH-1:0]      data_wdata_o,
  output logic [BYTE_ENABLE_BIT-1:0] data_be_o,
  output logic [ID_WIDTH-1:0]        data_id_o,
  input  logic                       data_gnt_i,
  input  logic                       data_r_valid_i,
  input  logic                       data_r_opc_i,
  input  logic [ID_WIDTH-1:0]        data_r_id_i,
  input  logic [DATA_WIDTH-1:0]      data_r_rdata_i,
  output logic                       data_r_valid_o,
  output logic                       data_r_opc_o,
  output logic [ID_WIDTH-1:0]        data_r_id_o,
  output logic [DATA_WIDTH-1:0]      data_r_rdata_o,
  output logic [IW-1:0]              inflight_o,
  output logic                       busy_o,
  output logic                       resp_err_o
);

  localparam int unsigned CW = cnt_width(DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]      add;
    logic                       we_n;
    logic [DATA_WIDTH-1:0]      wdata;
    logic [BYTE_ENABLE_BIT-1:0] be;
    logic [ID_WIDTH-1:0]        id;
  } req_t;

  req_t          wr_req, hd_req;
  logic [CW-1:0] count;
  logic          full, empty, push, pop;
  logic [IW-1:0] inflight_q, inflight_d;
  logic [IW:0]   inc_v, dec_v;
  logic          err_q, err_d;

  assign wr_req = '{
    add:   data_add_i,
    we_n:  data_we_n_i,
    wdata: data_wdata_i,
    be:    data_be_i,
    id:    data_id_i
  };

  assign data_gnt_o = ~full & ~flush_i
                    & (inflight_q < IW'(MAX_OUTSTANDING));
  assign data_req_o = ~empty & ~flush_i;
  assign push       = data_req_i & data_gnt_o;
  assign pop        = data_req_o & data_gnt_i;

  periph_fifo_id_mem #(
    .DW    ($bits(req_t)),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_req),
    .rdata_o (hd_req),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign data_add_o   = hd_req.add;
  assign data_we_n_o  = hd_req.we_n;
  assign data_wdata_o = hd_req.wdata;
  assign data_be_o    = hd_req.be;
  assign data_id_o    = hd_req.id;

  // Flushed entries were counted as accepted but will never be answered.
  always_comb begin
    inc_v = {1'b0, inflight_q} + (IW+1)'(push);
    dec_v = (IW+1)'(data_r_valid_i);
    if (flush_i) dec_v = dec_v + (IW+1)'(count);
    inflight_d = '0;
    if (inc_v >= dec_v) inflight_d = IW'(inc_v - dec_v);
    err_d = err_q | (data_r_valid_i & (inflight_q == '0));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign inflight_o = inflight_q;
  assign busy_o     = (inflight_q != '0);
  assign resp_err_o = err_q;

`ifdef PERIPH_FIFO_ID_RESP_REG_EN
  logic                  rvalid_q;
  logic                  ropc_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      ropc_q   <= 1'b0;
      rid_q    <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= data_r_valid_i;
      if (data_r_valid_i) begin
        ropc_q  <= data_r_opc_i;
        rid_q   <= data_r_id_i;
        rdata_q <= data_r_rdata_i;
      end
    end
  end

  assign data_r_valid_o = rvalid_q;
  assign data_r_opc_o   = ropc_q;
  assign data_r_id_o    = rid_q;
  assign data_r_rdata_o = rdata_q;
`else
  assign data_r_valid_o = data_r_valid_i;
  assign data_r_opc_o   = data_r_opc_i;
  assign data_r_id_o    = data_r_id_i;
  assign data_r_rdata_o = data_r_rdata_i;
`endif

endmodule

// File: tb/tb_periph_fifo_id_ot.sv
// Self-checking bench for periph_fifo_id_ot (default parameters).
// Honours PERIPH_FIFO_ID_RESP_REG_EN for response timing.
module tb_periph_fifo_id_ot;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int IDW = 8;
  localparam int BEW = 4;
  localparam int IFW = 4;

  logic           clk = 1'b0;
  logic           rst_ni = 1'b0;
  logic           flush_i = 1'b0;
  logic           data_req_i = 1'b0;
  logic [AW-1:0]  data_add_i = '0;
  logic           data_we_n_i = 1'b0;
  logic [DW-1:0]  data_wdata_i = '0;
  logic [BEW-1:0] data_be_i = '0;
  logic [IDW-1:0] data_id_i = '0;
  logic           data_gnt_o;
  logic           data_req_o;
  logic [AW-1:0]  data_add_o;
  logic           data_we_n_o;
  logic [DW-1:0]  data_wdata_o;
  logic [BEW-1:0] data_be_o;
  logic [IDW-1:0] data_id_o;
  logic           data_gnt_i = 1'b0;
  logic           data_r_valid_i = 1'b0;
  logic           data_r_opc_i = 1'b0;
  logic [IDW-1:0] data_r_id_i = '0;
  logic [DW-1:0]  data_r_rdata_i = '0;
  logic           data_r_valid_o;
  logic           data_r_opc_o;
  logic [IDW-1:0] data_r_id_o;
  logic [DW-1:0]  data_r_rdata_o;
  logic [IFW-1:0] inflight_o;
  logic           busy_o;
  logic           resp_err_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [IDW-1:0] id;
    logic [AW-1:0]  add;
    logic           we_n;
    logic [DW-1:0]  wdata;
    logic [BEW-1:0] be;
  } exp_t;

  exp_t sb[$];

  periph_fifo_id_ot dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .data_req_i     (data_req_i),
    .data_add_i     (data_add_i),
    .data_we_n_i    (data_we_n_i),
    .data_wdata_i   (data_wdata_i),
    .data_be_i      (data_be_i),
    .data_id_i      (data_id_i),
    .data_gnt_o     (data_gnt_o),
    .data_req_o     (data_req_o),
    .data_add_o     (data_add_o),
    .data_we_n_o    (data_we_n_o),
    .data_wdata_o   (data_wdata_o),
    .data_be_o      (data_be_o),
    .data_id_o      (data_id_o),
    .data_gnt_i     (data_gnt_i),
    .data_r_valid_i (data_r_valid_i),
    .data_r_opc_i   (data_r_opc_i),
    .data_r_id_i    (data_r_id_i),
    .data_r_rdata_i (data_r_rdata_i),
    .data_r_valid_o (data_r_valid_o),
    .data_r_opc_o   (data_r_opc_o),
    .data_r_id_o    (data_r_id_o),
    .data_r_rdata_o (data_r_rdata_o),
    .inflight_o     (inflight_o),
    .busy_o         (busy_o),
    .resp_err_o     (resp_err_o)
  );

  always #5 clk = ~clk;

  task automatic set_req(input logic [IDW-1:0] id);
    data_id_i    = id;
    data_add_i   = 32'h4000_0000 | {22'h0, id, 2'b00};
    data_we_n_i  = id[0];
    data_wdata_i = {4{id ^ 8'h3C}};
    data_be_i    = id[3:0] ^ 4'hA;
  endtask

  // One clock: scoreboard push/pop sampled mid-cycle, then advance.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (data_req_i && data_gnt_o) begin
      e.id = data_id_i; e.add = data_add_i; e.we_n = data_we_n_i;
      e.wdata = data_wdata_i; e.be = data_be_i;
      sb.push_back(e);
    end
    if (data_req_o && data_gnt_i) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_pop: got id %0h, required none", data_id_o);
      end else begin
        e = sb.pop_front();
        if (data_id_o !== e.id || data_add_o !== e.add ||
            data_we_n_o !== e.we_n || data_wdata_o !== e.wdata ||
            data_be_o !== e.be) begin
          errors++;
          $display("FAIL sb_pop: got id %0h add %0h, required id %0h add %0h",
                   data_id_o, data_add_o, e.id, e.add);
        end
      end
    end
    if (flush_i) sb.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic respond(input int n);
    data_r_valid_i = 1'b1;
    repeat (n) tick();
    data_r_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    #1;
    checks++; if (data_req_o !== 1'b0) begin errors++;
      $display("FAIL rst_req: got %b required 0", data_req_o); end
    checks++; if (data_gnt_o !== 1'b1) begin errors++;
      $display("FAIL rst_gnt: got %b required 1", data_gnt_o); end
    checks++; if (inflight_o !== 4'd0) begin errors++;
      $display("FAIL rst_inflight: got %0d required 0", inflight_o); end
    checks++; if (busy_o !== 1'b0) begin errors++;
      $display("FAIL rst_busy: got %b required 0", busy_o); end
    checks++; if (resp_err_o !== 1'b0) begin errors++;
      $display("FAIL rst_err: got %b required 0", resp_err_o); end
    checks++; if (data_id_o !== 8'h0 || data_add_o !== 32'h0) begin errors++;
      $display("FAIL rst_head: got %0h/%0h required 0/0", data_id_o, data_add_o); end
    checks++; if (data_r_valid_o !== 1'b0) begin errors++;
      $display("FAIL rst_rvalid: got %b required 0", data_r_valid_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    data_gnt_i = 1'b0;
    data_req_i = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      set_req(8'(i));
      checks++;
      if (data_gnt_o !== (i <= 4)) begin errors++;
        $display("FAIL fill_gnt%0d: got %b required %b", i, data_gnt_o, (i <= 4)); end
      if (i == 1) begin
        checks++; if (data_req_o !== 1'b0) begin errors++;
          $display("FAIL no_fallthru: got %b required 0", data_req_o); end
      end
      tick();
      if (i == 1) begin
        checks++; if (data_req_o !== 1'b1 || data_id_o !== 8'd1) begin errors++;
          $display("FAIL push_lat: got req %b id %0h required 1/1", data_req_o, data_id_o); end
      end
    end
    data_req_i = 1'b0;
    checks++; if (inflight_o !== 4'd4) begin errors++;
      $display("FAIL fill_inflight: got %0d required 4", inflight_o); end
    data_gnt_i = 1'b1;
    repeat (4) tick();
    checks++; if (data_req_o !== 1'b0 || sb.size() != 0) begin errors++;
      $display("FAIL fill_drain: got req %b left %0d required 0/0", data_req_o, sb.size()); end
    respond(4);
    checks++; if (inflight_o !== 4'd0 || busy_o !== 1'b0) begin errors++;
      $display("FAIL fill_clear: got %0d busy %b required 0/0", inflight_o, busy_o); end
  endtask

  task automatic test_outstanding();
    data_gnt_i = 1'b1;
    data_req_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_req(8'(8'h20 + i));
      checks++;
      if (data_gnt_o !== (i < 8)) begin errors++;
        $display("FAIL ot_gnt%0d: got %b required %b", i, data_gnt_o, (i < 8)); end
      tick();
    end
    data_req_i = 1'b0;
    checks++; if (inflight_o !== 4'd8 || data_gnt_o !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL ot_limit: got %0d gnt %b left %0d required 8/0/0",
               inflight_o, data_gnt_o, sb.size()); end
    respond(1);
    checks++; if (inflight_o !== 4'd7 || data_gnt_o !== 1'b1) begin errors++;
      $display("FAIL ot_release: got %0d gnt %b required 7/1", inflight_o, data_gnt_o); end
    respond(7);
    checks++; if (inflight_o !== 4'd0) begin errors++;
      $display("FAIL ot_clear: got %0d required 0", inflight_o); end
  endtask

  task automatic test_back_to_back();
    data_gnt_i = 1'b0;
    data_req_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_req(8'(8'h10 + i));
      tick();
    end
    checks++; if (inflight_o !== 4'd3) begin errors++;
      $display("FAIL b2b_pre: got %0d required 3", inflight_o); end
    set_req(8'h13);
    data_gnt_i = 1'b1;
    data_r_valid_i = 1'b1;
    tick();
    data_req_i = 1'b0;
    data_r_valid_i = 1'b0;
    checks++; if (inflight_o !== 4'd3 || data_id_o !== 8'h11) begin errors++;
      $display("FAIL b2b_same: got %0d head %0h required 3/11", inflight_o, data_id_o); end
    repeat (3) tick();
    checks++; if (data_req_o !== 1'b0 || sb.size() != 0) begin errors++;
      $display("FAIL b2b_count: got req %b left %0d required 0/0", data_req_o, sb.size()); end
    respond(3);
  endtask

  task automatic test_flush();
    data_gnt_i = 1'b0;
    data_req_i = 1'b1;
    for (int i = 0; i < 2; i++) begin set_req(8'(8'h30 + i)); tick(); end
    data_req_i = 1'b0;
    data_gnt_i = 1'b1;
    repeat (2) tick();
    data_gnt_i = 1'b0;
    data_req_i = 1'b1;
    for (int i = 0; i < 3; i++) begin set_req(8'(8'h40 + i)); tick(); end
    data_req_i = 1'b0;
    checks++; if (inflight_o !== 4'd5 || data_req_o !== 1'b1) begin errors++;
      $display("FAIL fl_pre: got %0d req %b required 5/1", inflight_o, data_req_o); end
    flush_i = 1'b1;
    #1;
    checks++; if (data_gnt_o !== 1'b0 || data_req_o !== 1'b0) begin errors++;
      $display("FAIL fl_during: got gnt %b req %b required 0/0", data_gnt_o, data_req_o); end
    tick();
    flush_i = 1'b0;
    #1;
    checks++; if (data_req_o !== 1'b0 || inflight_o !== 4'd2 || data_gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL fl_after: got req %b inflight %0d gnt %b required 0/2/1",
               data_req_o, inflight_o, data_gnt_o); end
    checks++; if (resp_err_o !== 1'b0) begin errors++;
      $display("FAIL fl_err: got %b required 0", resp_err_o); end
    respond(2);
    checks++; if (inflight_o !== 4'd0) begin errors++;
      $display("FAIL fl_clear: got %0d required 0", inflight_o); end
  endtask

  task automatic test_resp_err();
    data_r_valid_i = 1'b1;
    data_r_opc_i   = 1'b1;
    data_r_id_i    = 8'h5A;
    data_r_rdata_i = 32'hCAFE_F00D;
    #1;
`ifdef PERIPH_FIFO_ID_RESP_REG_EN
    checks++; if (data_r_valid_o !== 1'b0) begin errors++;
      $display("FAIL rsp_lat0: got %b required 0", data_r_valid_o); end
`else
    checks++; if (data_r_valid_o !== 1'b1 || data_r_id_o !== 8'h5A ||
                  data_r_rdata_o !== 32'hCAFE_F00D || data_r_opc_o !== 1'b1) begin
      errors++;
      $display("FAIL rsp_comb: got v %b id %0h required 1/5a", data_r_valid_o, data_r_id_o); end
`endif
    tick();
    data_r_valid_i = 1'b0;
    data_r_id_i    = 8'h00;
    data_r_rdata_i = '0;
    data_r_opc_i   = 1'b0;
    #1;
`ifdef PERIPH_FIFO_ID_RESP_REG_EN
    checks++; if (data_r_valid_o !== 1'b1 || data_r_id_o !== 8'h5A ||
                  data_r_rdata_o !== 32'hCAFE_F00D || data_r_opc_o !== 1'b1) begin
      errors++;
      $display("FAIL rsp_reg: got v %b id %0h required 1/5a", data_r_valid_o, data_r_id_o); end
`else
    checks++; if (data_r_valid_o !== 1'b0) begin errors++;
      $display("FAIL rsp_comb_off: got %b required 0", data_r_valid_o); end
`endif
    checks++; if (resp_err_o !== 1'b1 || inflight_o !== 4'd0) begin errors++;
      $display("FAIL rsp_err: got err %b inflight %0d required 1/0", resp_err_o, inflight_o); end
    repeat (3) tick();
    checks++; if (resp_err_o !== 1'b1) begin errors++;
      $display("FAIL rsp_sticky: got %b required 1", resp_err_o); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_outstanding();
    test_back_to_back();
    test_flush();
    test_resp_err();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
